// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width
// and the HI/LO write-select codes also used by the ALU decoder.
package div_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // HI/LO write-select codes; a divide result always writes both halves.
  typedef enum logic [1:0] {
    HILO_SEL_NONE = 2'd0,
    HILO_SEL_LO   = 2'd1,
    HILO_SEL_HI   = 2'd2,
    HILO_SEL_BOTH = 2'd3
  } hilo_sel_e;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor from the WIDTH+1-bit partial remainder, quotient bit = no borrow.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           no_borrow;

  // Trial subtraction; the difference always fits WIDTH bits because the
  // incoming remainder is below the divisor.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, divisor});
    rem_next  = no_borrow ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], no_borrow};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle divider controller for the EX stage. Stalls the pipeline while
// running and delivers quotient (LO) / remainder (HI) with a one-cycle strobe.
//
//  state | meaning
//  IDLE  | waiting for start; zero divisor goes straight to DONE
//  CALC  | WIDTH restoring iterations on the operand magnitudes
//  FIX   | apply result signs and register quotient/remainder
//  DONE  | one-cycle done/hilo_we pulse
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic             neg_q, neg_r;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand magnitudes; only signed operations take the absolute value.
  always_comb begin
    accept       = (state == IDLE) && start && !flush;
    dividend_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; flush aborts any non-idle state.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall = start && !flush;
        if (accept) state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (flush)               state_next = IDLE;
        else if (count == '0)    state_next = FIX;
      end
      FIX: begin
        stall      = 1'b1;
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        done       = !flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy    = (state != IDLE);
    hilo_we = done;
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor != '0) begin
              rem_r  <= '0;
              quo_r  <= dividend_mag;
              dvsr_r <= divisor_mag;
              neg_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r  <= is_signed && dividend[WIDTH-1];
              count  <= CNT_W'(WIDTH - 1);
            end else begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            rem_r <= rem_next;
            quo_r <= quo_next;
            if (count != '0) count <= count - 1'b1;
          end
        end
        FIX: begin
          // An aborted FIX leaves the previous result in place.
          if (!flush) begin
            quotient  <= neg_q ? (~quo_r + 1'b1) : quo_r;
            remainder <= neg_r ? (~rem_r + 1'b1) : rem_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes expected results computed
// with plain integer arithmetic; a negedge monitor pops on every done pulse.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         stall, busy, done, hilo_we;
  logic [W-1:0] quotient, remainder;

  div_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer division truncating toward zero, remainder takes the
  // dividend's sign; divide by zero yields all-ones / dividend.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int c);
    exp_t e;
    longint sa, sb;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.cyc = c + 1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.q = W'(sa / sb);
        e.r = W'(sa % sb);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.cyc = c + W + 2;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (done || hilo_we)) begin
      check("hilo_we_eq_done", {31'b0, hilo_we}, {31'b0, done});
      if (expq.size() == 0) begin
        check("unexpected_done", {31'b0, done}, '0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit expect_done);
    start = 1'b1;
    dividend = a;
    divisor = b;
    is_signed = s;
    if (expect_done) expq.push_back(model(a, b, s, cyc));
    #1;
    check("stall_start_cycle", {31'b0, stall}, 1);
    tick(1);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, '0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;

    tick(2);
    check("rst_busy", {31'b0, busy}, '0);
    check("rst_stall", {31'b0, stall}, '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    rst = 1'b0;
    tick(1);

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0, 1);
    tick(32);
    check("stall_cycle33", {31'b0, stall}, 1);
    tick(1);
    check("stall_done_cycle", {31'b0, stall}, '0);
    wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1);          wait_idle();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1);          wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);  wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1);  wait_idle();
    issue(32'h0000_1234, 32'd0, 1'b1, 1);          wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1);          wait_idle();

    // Flush in CALC: no result, stall drops, then a clean 9/3.
    issue(32'd1000, 32'd3, 1'b0, 0);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, '0);
    check("flush_stall", {31'b0, stall}, '0);
    issue(32'd9, 32'd3, 1'b0, 1);
    wait_idle();

    // start while busy must not re-capture.
    issue(32'd123456, 32'd789, 1'b0, 1);
    tick(9);
    start = 1'b1;
    dividend = 32'd5;
    divisor = 32'd1;
    tick(1);
    start = 1'b0;
    wait_idle();

    // flush in IDLE blocks acceptance.
    start = 1'b1;
    flush = 1'b1;
    dividend = 32'd50;
    divisor = 32'd5;
    #1;
    check("flush_idle_stall", {31'b0, stall}, '0);
    tick(1);
    start = 1'b0;
    flush = 1'b0;
    check("flush_idle_busy", {31'b0, busy}, '0);

    // Async reset mid-operation clears everything immediately.
    issue(32'd77777, 32'd13, 1'b0, 0);
    tick(19);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, '0);
    check("arst_stall", {31'b0, stall}, '0);
    check("arst_done", {31'b0, done}, '0);
    check("arst_hilo_we", {31'b0, hilo_we}, '0);
    check("arst_quotient", quotient, '0);
    check("arst_remainder", remainder, '0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Randomized operations, including zero divisors and small divisors.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 20));
        3:       b = -W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      issue(a, b, s, 1);
      wait_idle();
    end

    tick(3);
    check("scoreboard_empty", W'(expq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
